// File: rtl/bp_me_pkg.sv
// Shared NBF packet definitions used by the stream NBF sender and loader.
package bp_me_pkg;

    typedef enum logic [7:0] {
        e_nbf_wr32   = 8'h02,
        e_nbf_wr64   = 8'h03,
        e_nbf_fence  = 8'hFE,
        e_nbf_finish = 8'hFF
    } bp_nbf_opcode_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [39:0] addr;
        logic [63:0] data;
    } bp_nbf_s;

endpackage

// File: rtl/bsg_parallel_in_serial_out.sv
// Parallel-in serial-out: loads els_p words at once and emits them lowest word first.
// Latency: first word valid the cycle after load; one word per yumi.
// Backpressure: ready_o low while any word remains; data_o holds until yumi_i.
module bsg_parallel_in_serial_out #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       valid_i,
    input  logic [width_p*els_p-1:0]   data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    output logic                       last_o,
    input  logic                       yumi_i
);

    localparam int idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p*els_p-1:0] shift_data;
    logic [idx_width_lp-1:0]  idx;
    logic                     vld;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shift_data <= '0;
            idx        <= '0;
            vld        <= 1'b0;
        end else if (valid_i & ready_o) begin
            shift_data <= data_i;
            idx        <= '0;
            vld        <= 1'b1;
        end else if (yumi_i & vld) begin
            if (last_o) begin
                vld <= 1'b0;
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign ready_o = ~vld;
    assign valid_o = vld;
    assign last_o  = vld & (idx == idx_width_lp'(els_p - 1));
    // Zero when idle so the stream bus is quiet outside a packet.
    assign data_o  = vld ? shift_data[idx*width_p +: width_p] : '0;

endmodule

// File: rtl/bp_stream_nbf_sender.sv
// AXI-Lite writes become NBF packets sent as 32b flits; reads return packets sent (BP_STREAM_NBF_SENDER_WSTRB_CHECK_EN rejects partial strobes).
// Latency: first flit the cycle after the later of AW/W handshakes; B one cycle after last flit; R one cycle after AR.
// Backpressure: stream_ready_i stalls flits in place; AW/W are blocked from packet start until the B handshake.
module bp_stream_nbf_sender
    import bp_me_pkg::*;
#(
    parameter int          nbf_opcode_width_p = 8,
    parameter int          nbf_addr_width_p   = 40,
    parameter int          nbf_data_width_p   = 64,
    parameter logic [31:0] ctrl_addr_p        = 32'h0FFF_FFF0
) (
    input  logic        clk_i,
    input  logic        reset_n_i,

    input  logic [31:0] s_axil_awaddr_i,
    input  logic [2:0]  s_axil_awprot_i,
    input  logic        s_axil_awvalid_i,
    output logic        s_axil_awready_o,

    input  logic [31:0] s_axil_wdata_i,
    input  logic [3:0]  s_axil_wstrb_i,
    input  logic        s_axil_wvalid_i,
    output logic        s_axil_wready_o,

    output logic [1:0]  s_axil_bresp_o,
    output logic        s_axil_bvalid_o,
    input  logic        s_axil_bready_i,

    input  logic [31:0] s_axil_araddr_i,
    input  logic [2:0]  s_axil_arprot_i,
    input  logic        s_axil_arvalid_i,
    output logic        s_axil_arready_o,

    output logic [31:0] s_axil_rdata_o,
    output logic [1:0]  s_axil_rresp_o,
    output logic        s_axil_rvalid_o,
    input  logic        s_axil_rready_i,

    output logic        stream_v_o,
    output logic [31:0] stream_data_o,
    input  logic        stream_ready_i,

    output logic        done_o,
    output logic [31:0] pkt_count_o
);

    localparam int nbf_width_lp     = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
    localparam int nbf_num_flits_lp = (nbf_width_lp + 31) / 32;

    typedef enum logic [1:0] {e_idle, e_send, e_resp} state_e;

    state_e state, state_nxt;

    logic        aw_held, w_held;
    logic [31:0] aw_addr, w_data;
    logic        aw_fire, w_fire, aw_have, w_have;
    logic        busy, start, load, reject, last_fire;
    logic [31:0] addr_eff, data_eff;
    logic        is_ctrl, is_finish;

    logic [nbf_opcode_width_p-1:0]      opcode;
    logic [nbf_addr_width_p-1:0]        addr;
    logic [nbf_data_width_p-1:0]        data;
    logic [32*nbf_num_flits_lp-1:0]     pkt;

    logic        piso_ready, piso_last;
    logic        fin, done;
    logic [31:0] pkt_count;
    logic [1:0]  bresp;
    logic        rvalid;
    logic [31:0] rdata;
    logic        unused;

    assign busy             = (state != e_idle);
    assign s_axil_awready_o = ~aw_held & ~busy;
    assign s_axil_wready_o  = ~w_held & ~busy;
    assign aw_fire          = s_axil_awvalid_i & s_axil_awready_o;
    assign w_fire           = s_axil_wvalid_i & s_axil_wready_o;
    assign aw_have          = aw_held | aw_fire;
    assign w_have           = w_held | w_fire;
    // The later handshake bypasses its holding register so the packet loads in the same cycle.
    assign addr_eff         = aw_held ? aw_addr : s_axil_awaddr_i;
    assign data_eff         = w_held ? w_data : s_axil_wdata_i;
    assign start            = (state == e_idle) & aw_have & w_have;

`ifdef BP_STREAM_NBF_SENDER_WSTRB_CHECK_EN
    logic [3:0] w_strb;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            w_strb <= '0;
        else if (w_fire)
            w_strb <= s_axil_wstrb_i;
    end

    assign reject = ((w_held ? w_strb : s_axil_wstrb_i) != 4'hF);
    assign unused = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_araddr_i, piso_ready};
`else
    assign reject = 1'b0;
    assign unused = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_araddr_i, piso_ready, s_axil_wstrb_i};
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
        end else begin
            if (start)
                aw_held <= 1'b0;
            else if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= s_axil_awaddr_i;
            end
            if (start)
                w_held <= 1'b0;
            else if (w_fire) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata_i;
            end
        end
    end

    assign is_ctrl   = (addr_eff == ctrl_addr_p);
    assign is_finish = is_ctrl & data_eff[0];

    always_comb begin
        opcode = nbf_opcode_width_p'(e_nbf_wr32);
        addr   = nbf_addr_width_p'(addr_eff);
        data   = nbf_data_width_p'(data_eff);
        if (is_ctrl) begin
            opcode = data_eff[0] ? nbf_opcode_width_p'(e_nbf_finish) : nbf_opcode_width_p'(e_nbf_fence);
            addr   = '0;
            data   = '0;
        end
        pkt = '0;
        pkt[nbf_width_lp-1:0] = {opcode, addr, data};
    end

    bsg_parallel_in_serial_out #(
        .width_p (32),
        .els_p   (nbf_num_flits_lp)
    ) piso (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .valid_i   (load),
        .data_i    (pkt),
        .ready_o   (piso_ready),
        .valid_o   (stream_v_o),
        .data_o    (stream_data_o),
        .last_o    (piso_last),
        .yumi_i    (stream_v_o & stream_ready_i)
    );

    assign last_fire = stream_v_o & stream_ready_i & piso_last;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state <= e_idle;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            e_idle: begin
                if (start) begin
                    if (reject)
                        state_nxt = e_resp;
                    else begin
                        load      = 1'b1;
                        state_nxt = e_send;
                    end
                end
            end
            e_send:  if (last_fire) state_nxt = e_resp;
            e_resp:  if (s_axil_bready_i) state_nxt = e_idle;
            default: state_nxt = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fin       <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
            bresp     <= 2'b00;
        end else begin
            if (start) begin
                fin   <= is_finish;
                bresp <= reject ? 2'b10 : 2'b00;
            end
            if (last_fire) begin
                pkt_count <= pkt_count + 32'd1;
                if (fin)
                    done <= 1'b1;
            end
        end
    end

    // Reads sample the registered count, so a read racing the last flit sees the old value.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (s_axil_arvalid_i & s_axil_arready_o) begin
            rvalid <= 1'b1;
            rdata  <= pkt_count;
        end else if (rvalid & s_axil_rready_i) begin
            rvalid <= 1'b0;
        end
    end

    assign s_axil_bvalid_o  = (state == e_resp);
    assign s_axil_bresp_o   = bresp;
    assign s_axil_arready_o = ~rvalid;
    assign s_axil_rvalid_o  = rvalid;
    assign s_axil_rdata_o   = rdata;
    assign s_axil_rresp_o   = 2'b00;
    assign done_o           = done;
    assign pkt_count_o      = pkt_count;

endmodule

// File: tb/tb_bp_stream_nbf_sender.sv
// Scoreboarded bench: writes push expected flits/B responses, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bp_stream_nbf_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        stream_v, stream_ready, done;
    logic [31:0] stream_data, pkt_count;

    always #5 clk = ~clk;

    bp_stream_nbf_sender dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
        .stream_v_o(stream_v), .stream_data_o(stream_data), .stream_ready_i(stream_ready),
        .done_o(done), .pkt_count_o(pkt_count)
    );

    typedef struct { logic [31:0] dat; bit last; bit fin; } flit_t;

    flit_t       flit_q[$];
    logic [1:0]  b_q[$];
    logic [31:0] r_q[$];
    int unsigned model_count = 0;
    bit          model_done  = 0;
    int          checks = 0, errors = 0;
    bit          mon_en = 0, rnd_rdy = 0, rnd_b = 0, rnd_r = 0, rd_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: packet = {pad, opcode, addr, data}, flit k = bits [32k+:32].
    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [127:0] pkt;
        logic [7:0]   op;
        logic [39:0]  ad;
        logic [63:0]  dd;
        bit           rej;
        rej = 0;
`ifdef BP_STREAM_NBF_SENDER_WSTRB_CHECK_EN
        rej = (s != 4'hF);
`endif
        if (rej) begin
            b_q.push_back(2'b10);
            return;
        end
        if (a == 32'h0FFF_FFF0) begin
            op = d[0] ? 8'hFF : 8'hFE;
            ad = '0;
            dd = '0;
        end else begin
            op = 8'h02;
            ad = {8'h00, a};
            dd = {32'h0, d};
        end
        pkt = ({120'b0, op} << 104) | ({88'b0, ad} << 64) | {64'b0, dd};
        for (int k = 0; k < 4; k++)
            flit_q.push_back('{dat: pkt[32*k +: 32], last: (k == 3), fin: (op == 8'hFF)});
        b_q.push_back(2'b00);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("pkt_count", pkt_count, model_count);
            chk("done", {31'b0, done}, {31'b0, model_done});
            if (stream_v | bvalid)
                chk("accept_while_busy", {30'b0, awready, wready}, 32'd0);
            if (arvalid & arready)
                r_q.push_back(model_count);
            if (rvalid & rready) begin
                if (r_q.size() == 0) flag("unexpected_rvalid");
                else begin
                    chk("rdata", rdata, r_q.pop_front());
                    chk("rresp", {30'b0, rresp}, 32'd0);
                end
            end
            if (stream_v) begin
                if (flit_q.size() == 0) flag("unexpected_flit");
                else begin
                    chk("flit", stream_data, flit_q[0].dat);
                    if (stream_ready) begin
                        flit_t f;
                        f = flit_q.pop_front();
                        if (f.last) begin
                            model_count++;
                            if (f.fin) model_done = 1;
                        end
                    end
                end
            end
            if (bvalid & bready) begin
                if (b_q.size() == 0) flag("unexpected_bvalid");
                else chk("bresp", {30'b0, bresp}, {30'b0, b_q.pop_front()});
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) stream_ready = ($urandom_range(0, 3) != 0);
        if (rnd_b)   bready = $urandom_range(0, 1);
        if (rnd_r)   rready = $urandom_range(0, 1);
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        fork
            begin
                bit hs = 0;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr = a; awprot = 3'($urandom); awvalid = 1;
                for (int n = 0; n < 500 && !hs; n++) begin
                    @(negedge clk); hs = awready;
                    @(posedge clk); #1;
                end
                if (!hs) flag("aw_timeout");
                awvalid = 0;
            end
            begin
                bit hs = 0;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata = d; wstrb = s; wvalid = 1;
                for (int n = 0; n < 500 && !hs; n++) begin
                    @(negedge clk); hs = wready;
                    @(posedge clk); #1;
                end
                if (!hs) flag("w_timeout");
                wvalid = 0;
            end
        join
        expect_write(a, d, s);
    endtask

    task automatic do_read();
        bit hs = 0;
        araddr = $urandom; arprot = 3'($urandom); arvalid = 1;
        for (int n = 0; n < 500 && !hs; n++) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1;
        end
        if (!hs) flag("ar_timeout");
        arvalid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((flit_q.size() != 0 || b_q.size() != 0 || r_q.size() != 0) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 2000) flag("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit bv_seen;
        rst_n = 0;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        araddr = 0; arprot = 0; arvalid = 0;
        bready = 1; rready = 1; stream_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, awready}, 1);
        chk("rst_wready", {31'b0, wready}, 1);
        chk("rst_arready", {31'b0, arready}, 1);
        chk("rst_bvalid", {31'b0, bvalid}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_stream_v", {31'b0, stream_v}, 0);
        chk("rst_stream_data", stream_data, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_pkt_count", pkt_count, 0);
        rst_n = 1;
        @(posedge clk); #1;
        mon_en = 1;

        // Same-cycle AW/W with ready held: flits on N+1..N+4, bvalid at N+5.
        do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0);
        @(negedge clk); chk("lat_first_flit", {31'b0, stream_v}, 1);
        repeat (3) begin @(negedge clk); chk("lat_burst", {31'b0, stream_v}, 1); end
        @(negedge clk);
        chk("lat_bvalid", {31'b0, bvalid}, 1);
        chk("lat_stream_off", {31'b0, stream_v}, 0);
        @(posedge clk); #1;
        wait_idle();

        // W three cycles ahead of AW: nothing may stream before AW.
        do_write(32'h0000_2000, 32'hCAFE_F00D, 4'hF, 3, 0);
        wait_idle();

        // Toggled ready: 4 flits over 7 cycles, and a second write waits for B.
        stream_ready = 0;
        do_write(32'h1234_5678, 32'h0BAD_F00D, 4'hF, 0, 0);
        fork
            do_write(32'h0000_0040, 32'h5555_AAAA, 4'hF, 0, 0);
            begin
                stream_ready = 1; cnt = 0; bv_seen = 0;
                for (int c = 0; c < 20 && !bv_seen; c++) begin
                    @(negedge clk);
                    if (bvalid) bv_seen = 1;
                    else if (stream_v) cnt++;
                    @(posedge clk); #1;
                    stream_ready = ~stream_ready;
                end
                stream_ready = 1;
                chk("toggle_cycles", cnt, 7);
            end
        join
        wait_idle();

        // Finish control write sets done; a read then returns the packets sent.
        do_write(32'h0FFF_FFF0, 32'h0000_0001, 4'hF, 0, 1);
        wait_idle();
        chk("done_after_finish", {31'b0, done}, 1);
        do_read();
        wait_idle();

        // Partial strobe: rejected or sent depending on the build.
        do_write(32'h0000_1000, 32'h0000_1234, 4'h3, 1, 0);
        wait_idle();

        // Reset pulse after flit 1 aborts the packet and clears the count.
        do_write(32'h4000_0000, 32'h7777_0001, 4'hF, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 0; #1;
        chk("abort_stream_v", {31'b0, stream_v}, 0);
        chk("abort_pkt_count", pkt_count, 0);
        chk("abort_bvalid", {31'b0, bvalid}, 0);
        flit_q.delete(); b_q.delete(); r_q.delete();
        model_count = 0; model_done = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        do_write(32'h4000_0004, 32'h7777_0002, 4'hF, 0, 0);
        wait_idle();
        chk("post_abort_count", pkt_count, 1);

        // Randomized writes with concurrent reads and random backpressure.
        rnd_rdy = 1; rnd_b = 1; rnd_r = 1; rd_run = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, d;
                    logic [3:0]  s;
                    a = ($urandom_range(0, 4) == 0) ? 32'h0FFF_FFF0 : $urandom;
                    d = $urandom;
                    s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                    do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
                end
                wait_idle();
                rd_run = 0;
            end
            begin
                while (rd_run) begin
                    repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
                    if (rd_run) do_read();
                end
            end
        join
        rnd_rdy = 0; rnd_b = 0; rnd_r = 0;
        stream_ready = 1; bready = 1; rready = 1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
